// File: rtl/alu_pkg.sv
// Shared ALU control codes and requester id type.
// Imported by the arbiter, the shared-ALU top and the bench.
package alu_pkg;

  localparam int ID_W = 1;

  typedef logic [ID_W-1:0] req_id_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: fixed priority or round-robin.
// Ports: valid[1:0], en (slot free), grant[1:0] one-hot.
module rr_arb2
  import alu_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  // ptr names the requester favoured on a tie
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (FIXED_PRIO || !ptr)
                         ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arb2.sv
// One ALU shared by two valid/ready requesters via a one-entry
// issue register; responses tagged with the requester id.
module alu_arb2
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_ctr,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_ctr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output req_id_t         rsp_id,
  output logic [XLEN-1:0] rsp_y,
  output logic            rsp_zero,
  output logic            rsp_less
);

  logic            iss_valid;
  logic [XLEN-1:0] iss_a;
  logic [XLEN-1:0] iss_b;
  logic [3:0]      iss_ctr;
  req_id_t         iss_id;

  logic       free;
  logic [1:0] grant;

  // slot frees the same cycle the result is taken
  assign free = !iss_valid || rsp_ready;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .valid({req1_valid, req0_valid}),
    .en   (free && !rst),
    .grant(grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_ctr   <= ALU_ADD;
      iss_id    <= '0;
    end else if (grant[0]) begin
      iss_valid <= 1'b1;
      iss_a     <= req0_a;
      iss_b     <= req0_b;
      iss_ctr   <= req0_ctr;
      iss_id    <= req_id_t'(0);
    end else if (grant[1]) begin
      iss_valid <= 1'b1;
      iss_a     <= req1_a;
      iss_b     <= req1_b;
      iss_ctr   <= req1_ctr;
      iss_id    <= req_id_t'(1);
    end else if (rsp_ready) begin
      iss_valid <= 1'b0;
    end
  end

  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] y;

  assign shamt = iss_b[4:0];
  assign lt_s  = $signed(iss_a) < $signed(iss_b);
  assign lt_u  = iss_a < iss_b;

  always_comb begin
    y = '0;
    unique case (iss_ctr)
      ALU_ADD:  y = iss_a + iss_b;
      ALU_SUB:  y = iss_a - iss_b;
      ALU_SLL:  y = iss_a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  y = iss_a ^ iss_b;
      ALU_SRL:  y = iss_a >> shamt;
      ALU_SRA:  y = $signed(iss_a) >>> shamt;
      ALU_OR:   y = iss_a | iss_b;
      ALU_AND:  y = iss_a & iss_b;
      default:  y = '0;
    endcase
  end

  assign rsp_valid = iss_valid;
  assign rsp_id    = iss_id;
  assign rsp_y     = y;
  assign rsp_zero  = (y == '0);
  // less follows the compare flavour: unsigned only for SLTU
  assign rsp_less  = (iss_ctr == ALU_SLTU) ? lt_u : lt_s;

endmodule

// File: tb/tb_alu_arb2.sv
// Bench for alu_arb2: round-robin and fixed-priority instances,
// behavioural model checked every cycle plus directed literals.
module tb_alu_arb2;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 0, v1 = 0, rr = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0]  c0 = 0, c1 = 0;

  logic        o_r0[2], o_r1[2], o_rv[2];
  logic        o_z[2], o_l[2];
  req_id_t     o_id[2];
  logic [31:0] o_y[2];

  int checks = 0;
  int errors = 0;

  alu_arb2 #(.XLEN(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(o_r0[0]),
    .req0_a(a0), .req0_b(b0), .req0_ctr(c0),
    .req1_valid(v1), .req1_ready(o_r1[0]),
    .req1_a(a1), .req1_b(b1), .req1_ctr(c1),
    .rsp_valid(o_rv[0]), .rsp_ready(rr),
    .rsp_id(o_id[0]), .rsp_y(o_y[0]),
    .rsp_zero(o_z[0]), .rsp_less(o_l[0])
  );

  alu_arb2 #(.XLEN(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(o_r0[1]),
    .req0_a(a0), .req0_b(b0), .req0_ctr(c0),
    .req1_valid(v1), .req1_ready(o_r1[1]),
    .req1_a(a1), .req1_b(b1), .req1_ctr(c1),
    .rsp_valid(o_rv[1]), .rsp_ready(rr),
    .rsp_id(o_id[1]), .rsp_y(o_y[1]),
    .rsp_zero(o_z[1]), .rsp_less(o_l[1])
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: {y, zero, less}
  function automatic logic [33:0] alu_m(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] y;
    logic        less;
    int          sh;
    sh   = int'(b & 32'd31);
    less = (c == ALU_SLTU) ? (a < b)
                           : ($signed(a) < $signed(b));
    case (c)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU: y = (a < b) ? 1 : 0;
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = 0;
    endcase
    return {y, (y == 0), less};
  endfunction

  logic        m_v[2];
  logic [31:0] m_a[2], m_b[2];
  logic [3:0]  m_c[2];
  int          m_id[2];
  int          m_last[2];

  // k=0 round-robin instance, k=1 fixed-priority instance
  function automatic int m_grant(input int k);
    if (rst) return -1;
    if (m_v[k] && !rr) return -1;
    if (v0 && v1) begin
      if (k == 1) return 0;
      return (m_last[k] == 0) ? 1 : 0;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_v[k] <= 0; m_a[k] <= 0; m_b[k] <= 0;
        m_c[k] <= ALU_ADD; m_id[k] <= 0; m_last[k] <= 1;
      end else begin
        int g;
        g = m_grant(k);
        if (g >= 0) begin
          m_v[k]    <= 1;
          m_a[k]    <= (g == 0) ? a0 : a1;
          m_b[k]    <= (g == 0) ? b0 : b1;
          m_c[k]    <= (g == 0) ? c0 : c1;
          m_id[k]   <= g;
          m_last[k] <= g;
        end else if (rr) begin
          m_v[k] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      logic [33:0] e;
      g = m_grant(k);
      e = alu_m(m_a[k], m_b[k], m_c[k]);
      chk($sformatf("m_ready0[%0d]", k), o_r0[k], g == 0);
      chk($sformatf("m_ready1[%0d]", k), o_r1[k], g == 1);
      chk($sformatf("m_valid[%0d]", k), o_rv[k], m_v[k]);
      chk($sformatf("m_id[%0d]", k), o_id[k], m_id[k]);
      chk($sformatf("m_y[%0d]", k), o_y[k], e[33:2]);
      chk($sformatf("m_zero[%0d]", k), o_z[k], e[1]);
      chk($sformatf("m_less[%0d]", k), o_l[k], e[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1; v0 = 0; v1 = 0; rr = 0;
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  int g_exp[4] = '{0, 1, 0, 1};
  logic [31:0] t_a[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
  logic [31:0] t_b[3] = '{32'd1, 32'd1, 32'd7};
  logic [3:0]  t_c[3] = '{ALU_SLT, ALU_SLTU, ALU_SUB};
  logic [31:0] t_y[3] = '{32'd1, 32'd0, 32'd0};
  logic        t_z[3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    // reset state, with a request pending
    #3;
    v0 = 1;
    #1;
    chk("rst_valid", o_rv[0], 0);
    chk("rst_ready0", o_r0[0], 0);
    chk("rst_y", o_y[0], 0);
    chk("rst_zero", o_z[0], 1);
    chk("rst_less", o_l[0], 0);
    v0 = 0;
    @(negedge clk);
    #2;
    rst = 0;

    // 1: single SUB
    cyc();
    v0 = 1; a0 = 5; b0 = 3; c0 = ALU_SUB; rr = 1;
    @(negedge clk);
    chk("t1_ready0", o_r0[0], 1);
    cyc();
    v0 = 0;
    @(negedge clk);
    chk("t1_valid", o_rv[0], 1);
    chk("t1_id", o_id[0], 0);
    chk("t1_y", o_y[0], 2);
    chk("t1_zero", o_z[0], 0);
    chk("t1_less", o_l[0], 0);
    do_reset();

    // 2: round-robin alternation
    cyc();
    v0 = 1; a0 = 1; b0 = 1; c0 = ALU_ADD;
    v1 = 1; a1 = 1; b1 = 32'hFFFFFFFF; c1 = ALU_SLTU;
    rr = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) chk("t2_ready1", o_r1[0], g_exp[k]);
      if (k >= 1) begin
        chk("t2_valid", o_rv[0], 1);
        chk("t2_id", o_id[0], g_exp[k-1]);
        chk("t2_y", o_y[0], g_exp[k-1] == 1 ? 1 : 2);
        chk("t2_less", o_l[0], g_exp[k-1]);
      end
      cyc();
    end
    v0 = 0; v1 = 0;
    do_reset();

    // 3: fixed priority instance
    cyc();
    v0 = 1; v1 = 1; rr = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_ready0", o_r0[1], 1);
      chk("t3_ready1", o_r1[1], 0);
      if (k >= 1) chk("t3_id", o_id[1], 0);
      cyc();
    end
    v0 = 0;
    @(negedge clk);
    chk("t3_ready1_late", o_r1[1], 1);
    chk("t3_id_last", o_id[1], 0);
    cyc();
    v1 = 0;

    // 4: backpressure
    cyc();
    v1 = 1; a1 = 32'h80000000; b1 = 4; c1 = ALU_SRA;
    rr = 0;
    @(negedge clk);
    chk("t4_ready1", o_r1[0], 1);
    cyc();
    v1 = 0;
    v0 = 1; a0 = 2; b0 = 3; c0 = ALU_ADD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_y", o_y[0], 32'hF8000000);
      chk("t4_hold_id", o_id[0], 1);
      chk("t4_hold_r0", o_r0[0], 0);
      cyc();
    end
    rr = 1;
    @(negedge clk);
    chk("t4_take_r0", o_r0[0], 1);
    cyc();
    v0 = 0;
    @(negedge clk);
    chk("t4_valid", o_rv[0], 1);
    chk("t4_y", o_y[0], 5);
    chk("t4_id", o_id[0], 0);

    // 5: compares and zero flag
    for (int k = 0; k < 3; k++) begin
      cyc();
      v0 = 1; a0 = t_a[k]; b0 = t_b[k]; c0 = t_c[k];
      cyc();
      v0 = 0;
      @(negedge clk);
      chk("t5_y", o_y[0], t_y[k]);
      chk("t5_zero", o_z[0], t_z[k]);
    end

    // 6: async reset drops a pending result
    cyc();
    v0 = 1; a0 = 9; b0 = 9; c0 = ALU_ADD; rr = 0;
    cyc();
    v0 = 0;
    #2;
    chk("t6_pre_valid", o_rv[0], 1);
    rst = 1;
    #1;
    chk("t6_rst_valid_rr", o_rv[0], 0);
    chk("t6_rst_valid_fp", o_rv[1], 0);
    @(negedge clk);
    #1;
    rst = 0;
    v0 = 1; v1 = 1; rr = 1;
    #1;
    chk("t6_ready0", o_r0[0], 1);
    chk("t6_ready1", o_r1[0], 0);
    cyc();
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("t6_id", o_id[0], 0);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb2.md
Name: alu_arb2

Overview:
Shares one combinational ALU (the team's existing Alu unit) between two requesters, e.g. the execute stage and a branch/compare unit. Requests are arbitrated with valid/ready handshakes and captured in a one-entry issue register that feeds the ALU. Results return on a shared response channel tagged with the requester id. Sustained throughput is one op per cycle; latency is one cycle from accept to response.

Parameters:
XLEN, 32, operand/result width (the ALU is 32-bit; only 32 is supported)
FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a  in  XLEN  operand a
req0_b  in  XLEN  operand b
req0_ctr  in  4  ALU control code
req1_valid/req1_ready/req1_a/req1_b/req1_ctr  same as requester 0
rsp_valid  out  1  result held in the issue register
rsp_ready  in  1  consumer takes the result
rsp_id  out  1  0/1 = which requester issued
rsp_y  out  XLEN  ALU result
rsp_zero  out  1  ALU zero flag
rsp_less  out  1  ALU less flag

Behaviour:
- Reset (async, immediate) clears these:
  - issue-valid to 0, so rsp_valid=0 and both readys are 0 during reset.
  - priority pointer to 0 (requester 0 favoured first).
  - issue a/b/ctr/id to 0.
  - rsp_y/zero/less therefore show the ALU output for 0,0,add: y=0, zero=1, less=0.
- Slot free: free = !issue_valid | rsp_ready. Combinational, no bubble on back-to-back ops.
- Grant (combinational), only when free:
  - Only one requester valid: it wins.
  - Both valid, FIXED_PRIO=1: requester 0 wins.
  - Both valid, FIXED_PRIO=0: the requester at the pointer wins.
  - reqN_ready = grantN. At most one ready is high. No ready when neither is valid.
- Accept (rising edge): on grantN, issue register <= {a,b,ctr,id=N} and issue_valid<=1.
- Completion: on rsp_valid & rsp_ready with no grant, issue_valid<=0. Simultaneous complete and grant: the register reloads and issue_valid stays 1.
- Pointer update (round-robin): on any grant to N, pointer <= ~N. No update without a grant. Starvation bound: with the slot free, a waiting requester is served within 2 grants.
- Outputs rsp_y/zero/less are driven combinationally by the ALU from issue register contents.
- While rsp_valid=1 and rsp_ready=0:
  - All rsp_* outputs are stable.
  - Both readys are 0.
- Requesters must hold a/b/ctr stable while valid and not ready. No combinational path from req*_a/b/ctr to rsp_*.
- rsp_ready while rsp_valid=0 has no effect.
- Reset asserted mid-operation drops the pending result. No response is produced for it.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants: ADD=4'b0000, SUB=4'b1000, SLL=4'b0001, SLT=4'b0010, SLTU=4'b0011, XOR=4'b0100, SRL=4'b0101, SRA=4'b1101, OR=4'b0110, AND=4'b0111.
  - Requester-id width constant.
- One natural sub-module: rr_arb2. Inputs: two-way valid, enable (=free), FIXED_PRIO. Outputs: one-hot grant; it owns the pointer flop.
- The ALU is instantiated directly inside alu_arb2.

Test Plan:
1. Reset, then req0 only, a=5, b=3, ctr=SUB, rsp_ready=1 -> req0_ready=1 in cycle 0. Next cycle: rsp_valid=1, id=0, y=2, zero=0, less=0.
2. Both valid every cycle, rsp_ready=1, FIXED_PRIO=0. Req0 ADD 1+1; req1 SLTU a=1, b=0xFFFFFFFF. Expect:
   - Grants alternate 0,1,0,1.
   - Responses alternate y=2 / y=1 (less=1), one per cycle, no bubbles.
3. FIXED_PRIO=1, both valid for 4 cycles -> four responses, all id=0. req1_ready stays 0 until req0_valid drops.
4. Backpressure: accept req1 SRA a=0x80000000, b=4. Hold rsp_ready=0 for 3 cycles. Expect:
   - rsp_y=0xF8000000 is stable; both readys are 0.
   - With rsp_ready=1 and req0 valid in the same cycle, req0 is accepted and rsp_valid stays 1 with the new result.
5. Signed vs unsigned compare: SLT a=0xFFFFFFFF, b=1 -> y=1. SLTU with the same operands -> y=0. Zero flag: SUB 7-7 -> zero=1, y=0.
6. Assert rst asynchronously while rsp_valid=1 and rsp_ready=0 -> rsp_valid drops to 0 immediately. After release, both requesters valid -> requester 0 is granted first.
